// File: rtl/tomasulo_pkg.sv
// Shared CDB scheduling types and default sizes for the scheduler,
// the reservation stations and the CDB driver.
package tomasulo_pkg;

    localparam int M_DEF     = 4;
    localparam int L_DEF     = 4;
    localparam int LAT_W_DEF = $clog2(L_DEF + 1);
    localparam int IDX_W_DEF = (M_DEF > 1) ? $clog2(M_DEF) : 1;

    // Sized L+1 so a station can test sch_r[its_latency] without an offset.
    typedef logic [L_DEF:0] sch_t;

    typedef struct packed {
        logic                 booked;
        logic [IDX_W_DEF-1:0] owner;
    } cdb_slot_t;

endpackage

// File: rtl/tomasulo_cdb_sched_if.sv
// Station-facing bus of the CDB slot scheduler: requests and latencies in,
// grant, booking vector, CDB mux select and conflict count out.
interface tomasulo_cdb_sched_if
    import tomasulo_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int L     = L_DEF,
    parameter int LAT_W = $clog2(L + 1)
);
    logic [M-1:0]            req;
    logic [M-1:0][LAT_W-1:0] req_lat;
    logic [M-1:0]            gnt;
    logic [L:0]              sch_r;
    logic                    cdb_sel_vld;
    logic [M-1:0]            cdb_sel;
    logic [15:0]             conflict_cnt_r;

    modport master (
        output req, req_lat,
        input  gnt, sch_r, cdb_sel_vld, cdb_sel, conflict_cnt_r
    );

    modport slave (
        input  req, req_lat,
        output gnt, sch_r, cdb_sel_vld, cdb_sel, conflict_cnt_r
    );
endinterface

// File: rtl/tomasulo_rr_arb.sv
// Generic N-way round-robin arbiter: one-hot grant to the first eligible
// requester at or after the pointer; the pointer moves past the winner on adv.
module tomasulo_rr_arb #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] elig,
    input  logic         adv,
    output logic [N-1:0] gnt
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] pos, win;
    logic [PTR_W:0]   sum;
    logic [2*N-1:0]   dbl;
    logic [N-1:0]     rot;
    logic             found;

    // NOTE: every output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        dbl   = {elig, elig} >> ptr_q;
        rot   = dbl[N-1:0];
        found = |rot;
        pos   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) pos = PTR_W'(i);
        end
        sum = {1'b0, ptr_q} + {1'b0, pos};
        if (sum >= (PTR_W + 1)'(N)) sum = sum - (PTR_W + 1)'(N);
        win = sum[PTR_W-1:0];
        gnt = '0;
        if (found) gnt[win] = 1'b1;
    end

    // Kept apart from the grant logic so adv (derived from gnt) forms no loop.
    always_comb begin
        ptr_d = ptr_q;
        if (adv && found) ptr_d = (win == PTR_W'(N - 1)) ? '0 : win + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end
endmodule

// File: rtl/tomasulo_cdb_sched.sv
// CDB slot scheduler: books a future CDB slot per grant, tracks slot owners
// to drive the CDB result-mux select, and counts refused-request cycles.
module tomasulo_cdb_sched
    import tomasulo_pkg::*;
#(
    parameter int M     = M_DEF,
    parameter int L     = L_DEF,
    parameter int LAT_W = $clog2(L + 1)
) (
    input logic                 clk,
    input logic                 rst,
    tomasulo_cdb_sched_if.slave bus
);
    localparam int IDX_W = (M > 1) ? $clog2(M) : 1;

    logic [L:0]             sch_q, sch_d;
    logic [L:0][IDX_W-1:0]  owner_q, owner_d;
    logic [15:0]            cnt_q, cnt_d;
    logic [M-1:0]           lat_ok, slot_busy, elig, gnt;
    logic                   any_gnt, book;
    logic [IDX_W-1:0]       gnt_idx;
    logic [LAT_W-1:0]       gnt_lat;

    always_comb begin
        for (int i = 0; i < M; i++) begin
            lat_ok[i]    = (bus.req_lat[i] != '0) && (bus.req_lat[i] <= LAT_W'(L));
            slot_busy[i] = 1'b0;
            for (int k = 1; k <= L; k++) begin
                if (bus.req_lat[i] == LAT_W'(k)) slot_busy[i] = sch_q[k];
            end
            elig[i] = bus.req[i] && lat_ok[i] && !slot_busy[i];
        end
    end

    tomasulo_rr_arb #(.N(M)) u_arb (
        .clk  (clk),
        .rst  (rst),
        .elig (elig),
        .adv  (any_gnt),
        .gnt  (gnt)
    );

    assign any_gnt = |gnt;

    always_comb begin
        gnt_idx = '0;
        gnt_lat = '0;
        for (int i = 0; i < M; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_lat = bus.req_lat[i];
            end
        end
    end

    // Slot k+1 moves to slot k; a latency-n grant lands in slot n-1 after the move.
    always_comb begin
        sch_d   = '0;
        owner_d = '0;
        book    = 1'b0;
        for (int k = 0; k < L; k++) begin
            book       = any_gnt && (gnt_lat == LAT_W'(k + 1));
            sch_d[k]   = sch_q[k + 1] | book;
            owner_d[k] = book ? gnt_idx : owner_q[k + 1];
        end
        // Illegal latencies are never eligible, so they cannot count as refusals.
        cnt_d = cnt_q;
        if (|(bus.req & lat_ok & slot_busy) && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
    end

    // NOTE: the ownership array is reset too, so cdb_sel never shows a stale owner after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sch_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else begin
            sch_q   <= sch_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.gnt            = gnt;
    assign bus.sch_r          = sch_q;
    assign bus.cdb_sel_vld    = sch_q[0];
    assign bus.cdb_sel        = sch_q[0] ? (M'(1) << owner_q[0]) : '0;
    assign bus.conflict_cnt_r = cnt_q;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < M; i++) begin
                assert (!bus.req[i] || lat_ok[i])
                    else $warning("station %0d requested with out-of-range req_lat %0d", i, bus.req_lat[i]);
            end
        end
    end
endmodule

// File: doc/tomasulo_cdb_sched.md
# tomasulo_cdb_sched

Books Common Data Bus (CDB) slots ahead of time and arbitrates between reservation stations that want to issue. Each station asks for a grant together with its functional-unit latency. The block grants at most one station per cycle, and only if that station's result would land in a free CDB slot. It keeps a per-slot ownership record, so it also drives the CDB result-mux select in the cycle each result arrives. It sits between the reservation stations / functional units and the CDB driver.

## Interface
- `M`, default 4: number of requesting reservation stations.
- `L`, default 4: maximum supported latency in cycles (grant to CDB slot); `L` ≥ 1.
- `LAT_W`, default `$clog2(L+1)`: width of a latency field.
- `clk`  in  1: clock.
- `rst`  in  1: reset; asynchronous, active-low.
- `req`  in  M: per-station issue request.
- `req_lat`  in  M×LAT_W: latency of each station's FU; legal range 1..`L`.
- `gnt`  out  M: one-hot grant, combinational, same cycle as `req`.
- `sch_r`  out  L+1: slot-booking vector, registered. Bit k = CDB slot k cycles ahead is booked.
- `cdb_sel_vld`  out  1: a booked result occupies the CDB this cycle; equals `sch_r[0]`.
- `cdb_sel`  out  M: one-hot owner of the current slot; `'0` when `cdb_sel_vld`=0.
- `conflict_cnt_r`  out  16: count of cycles in which some request was refused because its slot was taken; saturating.

## Operation
- **Eligibility:** station i is eligible when `req[i]`, and `req_lat[i]` is in 1..`L`, and `~sch_r[req_lat[i]]`.
- **Arbitration:** round-robin among eligible stations, starting at `rr_ptr_r`. At most one `gnt` bit is set. `gnt`=0 when nothing is eligible.
- **Pointer update:** on a grant to station i, `rr_ptr_r` ← (i+1) mod M. With no grant the pointer holds.
- **Booking shift:** `sch_w[k]` = `sch_r[k+1]` | (grant ∧ granted latency == k+1), for k = 0..L-1. `sch_w[L]` = 0.
- **Ownership:** `owner_r[k]` (log2 M bits per slot) shifts in lockstep with `sch_r`. A grant writes the granted index into slot `lat-1` of the next state.
- **CDB select:** `cdb_sel` = onehot(`owner_r[0]`) gated by `sch_r[0]`.
- **Illegal latency:** a request with `req_lat` of 0 or greater than `L` is never granted, and a simulation assertion fires. This case does not count as a conflict.
- **Conflict counter:** increments when any `req[i]` is refused because its slot is booked, regardless of whether another station was granted. Saturates at 0xFFFF.
- **Request hold:** stations hold `req` until granted. The block keeps no per-station request memory.

## Timing
- **Reset values:** `sch_r`=0, `owner_r`=0, `rr_ptr_r`=0, `conflict_cnt_r`=0. Therefore `cdb_sel_vld`=0 and `cdb_sel`=0.
- **Reset during operation:** pending bookings are lost and the block returns to the reset state. Upstream pipelines are reset together with this block.
- **Grant-to-CDB timing:** a grant in cycle t with latency n gives `cdb_sel_vld`=1 and `cdb_sel`=onehot(i) in cycle t+n exactly, and in no other cycle.
- **Latency 1:** booked into `sch_w[0]`; visible on the CDB in the next cycle.
- **Latency `L`:** uses bit `L-1` after the shift. `sch_r[L]` is always 0 after reset.
- **Same-slot requests:** two requests in the same cycle whose latencies target the same slot get one grant only (round-robin). The loser retries the next cycle, when that slot is 1 cycle closer. The loser is granted only if its latency then maps to a free bit.
- **Different-slot requests:** only one grant per cycle, even if the requests target different free slots.
- **Steady state:** back-to-back grants with latency n to a single station give a continuous run of `cdb_sel_vld`. No bubble is inserted by the scheduler.
- **Grant path:** `gnt` is purely combinational from `req`, `req_lat`, `sch_r` and `rr_ptr_r`. The registered state updates on the next `clk` edge.

## Structure
- **Shared package:** `cdb_slot_t` and the `L`/`M` defaults go in `tomasulo_pkg`. `sch_t` there is sized `L+1` so the reservation stations index `sch_r[LATENCY_N]` directly.
- **Sub-module:** one, `tomasulo_rr_arb`. It is a generic M-way round-robin arbiter with an internal pointer, taking an eligible vector and an advance strobe and producing a one-hot grant. The slot shift register, ownership array and counter stay in the top module.

## Test plan
- **Single grant:** after reset, `req`=0001, `req_lat[0]`=3 in cycle 0 → `gnt`=0001 in cycle 0; `sch_r`=0b00100 in cycle 1; `cdb_sel_vld`=1 and `cdb_sel`=0001 in cycle 3 only.
- **Same-slot collision:** station 0 granted with latency 3 in cycle 0; station 1 requests latency 2 in cycle 1 → `gnt`=0 in cycle 1 and `conflict_cnt_r`=1 in cycle 2. Station 1 holds the request and is granted in cycle 2 (slot 4); `cdb_sel` is 0001 in cycle 3 and 0010 in cycle 4.
- **Round-robin fairness:** all four stations request continuously with latency 1 → grants rotate 0001, 0010, 0100, 1000, 0001. `cdb_sel_vld` stays 1 from cycle 1 onward.
- **Illegal latency:** `req_lat`=0 or 5 with `L`=4 → no grant, assertion fires, `sch_r` is unchanged, `conflict_cnt_r` is unchanged.
- **Asynchronous reset:** assert `rst`=0 mid-cycle with `sch_r`=0b01110 → `sch_r`, `cdb_sel_vld` and `conflict_cnt_r` go to 0 immediately without waiting for `clk`. After release, a latency-1 request is granted on the first cycle.
- **Counter saturation:** force 70000 refused cycles → `conflict_cnt_r` holds at 0xFFFF.
